// File: rtl/fpdiv_pkg.sv
// ---------------------------------------------------------------------------
// fpdiv_pkg
// Shared types and constants for the Goldschmidt divider sequencer.
//   fpdiv_state_t : FSM state encoding for fpdiv_ctrl
//   SEL_*         : sel_mux4 operand-pair encodings
//   SEL2_*        : sel_mux2 operand-source encodings
// ---------------------------------------------------------------------------
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_N = 3'd1,
    LOAD_D = 3'd2,
    ITER_A = 3'd3,
    ITER_B = 3'd4,
    DONE   = 3'd5
  } fpdiv_state_t;

  // sel_mux4: which product feeds the multiplier output register
  localparam logic [1:0] SEL_N_IA = 2'b00;
  localparam logic [1:0] SEL_D_IA = 2'b01;
  localparam logic [1:0] SEL_A_C  = 2'b10;
  localparam logic [1:0] SEL_B_C  = 2'b11;

  // sel_mux2: second multiplier operand source
  localparam logic SEL2_IA = 1'b0;
  localparam logic SEL2_C  = 1'b1;

endpackage

// File: rtl/fpdiv_ctrl.sv
// ---------------------------------------------------------------------------
// fpdiv_ctrl
// Sequencing FSM for the Goldschmidt fpdiv datapath. One numerator scaling
// step (N*IA->A), one denominator scaling step (D*IA->B), then ITERS
// refinement pairs (A*C->A, B*C->B), followed by a one-cycle done pulse.
//
// Parameters:
//   ITERS  number of refinement pairs (0..15)
//   CNT_W  iteration counter width, 2**CNT_W > ITERS
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   start     in   division request, honoured only in IDLE or DONE
//   conv      in   (FPDIV_EARLY_EXIT_EN only) B has converged, sampled in ITER_B
//   busy      out  high in LOAD_N, LOAD_D, ITER_A, ITER_B
//   done      out  one-cycle pulse, datapath result valid
//   sel_mux2  out  0 = IA operand, 1 = C register
//   sel_mux4  out  product select (N*IA, D*IA, A*C, B*C)
//   en_a      out  load register A
//   en_b      out  load register B
//   iter_cnt  out  completed refinement iterations
//
// Optional feature macro: FPDIV_EARLY_EXIT_EN adds the conv input, which
// terminates refinement early when asserted in ITER_B.
// ---------------------------------------------------------------------------
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef FPDIV_EARLY_EXIT_EN
  input  logic             conv,
`endif
  output logic             busy,
  output logic             done,
  output logic             sel_mux2,
  output logic [1:0]       sel_mux4,
  output logic             en_a,
  output logic             en_b,
  output logic [CNT_W-1:0] iter_cnt
);

  // Compared one bit wider than the counter so iter_cnt+1 cannot wrap.
  localparam logic [CNT_W:0] ITERS_C = (CNT_W + 1)'(ITERS);

  fpdiv_state_t     state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             last_pair;
  logic             exit_early;

  assign last_pair = (({1'b0, iter_cnt_q} + (CNT_W + 1)'(1)) >= ITERS_C);

`ifdef FPDIV_EARLY_EXIT_EN
  assign exit_early = conv;
`else
  assign exit_early = 1'b0;
`endif

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD_N;
          iter_cnt_d = '0;
        end
      end
      LOAD_N: state_d = LOAD_D;
      LOAD_D: begin
        if (ITERS > 0) state_d = ITER_A;
        else           state_d = DONE;
      end
      ITER_A: state_d = ITER_B;
      ITER_B: begin
        // The pair just finished counts even when leaving early on conv.
        iter_cnt_d = iter_cnt_q + CNT_W'(1);
        if (last_pair || exit_early) state_d = DONE;
        else                         state_d = ITER_A;
      end
      DONE: begin
        // Back-to-back request skips IDLE entirely.
        if (start) begin
          state_d    = LOAD_N;
          iter_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    sel_mux2 = SEL2_IA;
    sel_mux4 = SEL_N_IA;
    en_a     = 1'b0;
    en_b     = 1'b0;
    case (state_q)
      LOAD_N: begin
        busy = 1'b1;
        en_a = 1'b1;
      end
      LOAD_D: begin
        busy     = 1'b1;
        sel_mux4 = SEL_D_IA;
        en_b     = 1'b1;
      end
      ITER_A: begin
        busy     = 1'b1;
        sel_mux2 = SEL2_C;
        sel_mux4 = SEL_A_C;
        en_a     = 1'b1;
      end
      ITER_B: begin
        busy     = 1'b1;
        sel_mux2 = SEL2_C;
        sel_mux4 = SEL_B_C;
        en_b     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpdiv_ctrl
// Bench for fpdiv_ctrl. Two instances: ITERS=6 (main) and ITERS=0.
// Stimulus vectors {start, reset, conv, expected outputs} are built per
// scenario and applied in a loop; expected outputs go through a queue.
// ---------------------------------------------------------------------------
module tb_fpdiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ITERS=6 instance
  logic       reset, start, conv;
  logic       busy, done, sel_mux2, en_a, en_b;
  logic [1:0] sel_mux4;
  logic [3:0] iter_cnt;

  // ITERS=0 instance
  logic       reset0, start0, conv0;
  logic       busy0, done0, sel_mux20, en_a0, en_b0;
  logic [1:0] sel_mux40;
  logic [3:0] iter_cnt0;

  fpdiv_ctrl #(.ITERS(6), .CNT_W(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef FPDIV_EARLY_EXIT_EN
    .conv     (conv),
`endif
    .busy     (busy),
    .done     (done),
    .sel_mux2 (sel_mux2),
    .sel_mux4 (sel_mux4),
    .en_a     (en_a),
    .en_b     (en_b),
    .iter_cnt (iter_cnt)
  );

  fpdiv_ctrl #(.ITERS(0), .CNT_W(4)) u_dut0 (
    .clk      (clk),
    .reset    (reset0),
    .start    (start0),
`ifdef FPDIV_EARLY_EXIT_EN
    .conv     (conv0),
`endif
    .busy     (busy0),
    .done     (done0),
    .sel_mux2 (sel_mux20),
    .sel_mux4 (sel_mux40),
    .en_a     (en_a0),
    .en_b     (en_b0),
    .iter_cnt (iter_cnt0)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       sel2;
    logic [1:0] sel4;
    logic       ea;
    logic       eb;
    logic [3:0] cnt;
  } obs_t;

  typedef struct packed {
    logic start;
    logic rst_n;
    logic conv;
    obs_t exp;
  } vec_t;

  vec_t vq[$];
  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Expected outputs k cycles after the start edge (k=1 is LOAD_N) for n pairs.
  function automatic obs_t exp_at(int k, int n);
    obs_t e;
    int   j;
    e = '0;
    if (k == 1) begin
      e.busy = 1'b1; e.ea = 1'b1;
    end else if (k == 2) begin
      e.busy = 1'b1; e.sel4 = 2'b01; e.eb = 1'b1;
    end else if (k <= 2 + 2 * n) begin
      j      = k - 3;
      e.busy = 1'b1;
      e.sel2 = 1'b1;
      e.cnt  = 4'(j / 2);
      if (j % 2 == 0) begin e.sel4 = 2'b10; e.ea = 1'b1; end
      else            begin e.sel4 = 2'b11; e.eb = 1'b1; end
    end else if (k == 3 + 2 * n) begin
      e.done = 1'b1; e.cnt = 4'(n);
    end
    return e;
  endfunction

  function automatic obs_t idle_exp(int c);
    obs_t e;
    e     = '0;
    e.cnt = 4'(c);
    return e;
  endfunction

  task automatic add(input logic s, input logic r, input logic c, input obs_t e);
    vec_t v;
    v.start = s; v.rst_n = r; v.conv = c; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic run_vecs(input string name, input int which);
    obs_t got, want;
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (which == 0) begin
        start = vq[i].start; reset = vq[i].rst_n; conv = vq[i].conv;
      end else begin
        start0 = vq[i].start; reset0 = vq[i].rst_n; conv0 = vq[i].conv;
      end
      sb.push_back(vq[i].exp);
      @(posedge clk);
      #1;
      if (which == 0) got = {busy, done, sel_mux2, sel_mux4, en_a, en_b, iter_cnt};
      else            got = {busy0, done0, sel_mux20, sel_mux40, en_a0, en_b0, iter_cnt0};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s[%0d] busy,done,sel2,sel4,ea,eb,cnt got=%b_%b_%b_%b_%b_%b_%h want=%b_%b_%b_%b_%b_%b_%h",
                 name, i, got.busy, got.done, got.sel2, got.sel4, got.ea, got.eb, got.cnt,
                 want.busy, want.done, want.sel2, want.sel4, want.ea, want.eb, want.cnt);
      end
      if (got.ea && got.eb) begin
        errors++;
        $display("FAIL %s[%0d] en_a and en_b both high", name, i);
      end
    end
    vq.delete();
    @(negedge clk);
    start = 1'b0; conv = 1'b0; reset = 1'b1;
    start0 = 1'b0; conv0 = 1'b0; reset0 = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; conv = 1'b0;
    reset0 = 1'b0; start0 = 1'b0; conv0 = 1'b0;

    // Reset state, reset dominating start
    add(0, 0, 0, idle_exp(0));
    add(1, 0, 0, idle_exp(0));
    add(0, 1, 0, idle_exp(0));
    run_vecs("reset", 0);

    // Nominal operation, then IDLE holds the count
    add(1, 1, 0, exp_at(1, 6));
    for (int k = 2; k <= 15; k++) add(0, 1, 0, exp_at(k, 6));
    add(0, 1, 0, idle_exp(6));
    add(0, 1, 0, idle_exp(6));
    run_vecs("nominal", 0);

    // Start pulses in cycles 4 and 9 are ignored
    for (int k = 1; k <= 15; k++) add((k == 1 || k == 5 || k == 10), 1, 0, exp_at(k, 6));
    add(0, 1, 0, idle_exp(6));
    run_vecs("ignored_start", 0);

    // Start held high: done at 15, 30, 45 with no IDLE gap
    for (int r = 0; r < 3; r++)
      for (int k = 1; k <= 15; k++) add(1, 1, 0, exp_at(k, 6));
    add(0, 1, 0, idle_exp(6));
    run_vecs("back_to_back", 0);

    // Reset sampled at the cycle-7 edge, then a full operation
    for (int k = 1; k <= 7; k++) add((k == 1), 1, 0, exp_at(k, 6));
    add(0, 0, 0, idle_exp(0));
    add(0, 1, 0, idle_exp(0));
    add(0, 1, 0, idle_exp(0));
    add(1, 1, 0, exp_at(1, 6));
    for (int k = 2; k <= 15; k++) add(0, 1, 0, exp_at(k, 6));
    add(0, 1, 0, idle_exp(6));
    run_vecs("midop_reset", 0);

    // Reset in DONE wins over a back-to-back start
    for (int k = 1; k <= 15; k++) add((k == 1), 1, 0, exp_at(k, 6));
    add(1, 0, 0, idle_exp(0));
    add(0, 1, 0, idle_exp(0));
    run_vecs("reset_in_done", 0);

`ifdef FPDIV_EARLY_EXIT_EN
    // conv in ITER_A ignored; conv in the second ITER_B ends the run
    add(1, 1, 0, exp_at(1, 6));
    add(0, 1, 0, exp_at(2, 6));
    add(0, 1, 0, exp_at(3, 6));
    add(0, 1, 1, exp_at(4, 6));
    add(0, 1, 0, exp_at(5, 6));
    add(0, 1, 1, exp_at(6, 6));
    add(0, 1, 1, exp_at(3 + 2 * 2, 2));
    add(0, 1, 0, idle_exp(2));
    run_vecs("early_exit", 0);
`endif

    // ITERS=0: reset, single op, back-to-back pair
    add(0, 0, 0, idle_exp(0));
    add(0, 1, 0, idle_exp(0));
    add(1, 1, 0, exp_at(1, 0));
    add(0, 1, 0, exp_at(2, 0));
    add(0, 1, 0, exp_at(3, 0));
    add(0, 1, 0, idle_exp(0));
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= 3; k++) add(1, 1, 0, exp_at(k, 0));
    add(0, 1, 0, idle_exp(0));
    run_vecs("iters0", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
